// File: rtl/mor1kx_spr_gpr_initiator.sv
// SPR-bus initiator that bursts GPR reads/writes through SPR group 0 on behalf
// of a host command port, with a per-access ack timeout and abort.
module mor1kx_spr_gpr_initiator #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int GPR_ADDR_WIDTH       = 5,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic                            cmd_we_i,
  input  logic [GPR_ADDR_WIDTH-1:0]       cmd_gpr_i,
  input  logic [GPR_ADDR_WIDTH:0]         cmd_len_i,
  input  logic                            wdat_valid_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wdat_i,
  output logic                            wdat_ready_o,
  output logic                            rdat_valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rdat_o,
  input  logic                            rdat_ready_i,
  input  logic                            abort_i,
  output logic                            done_o,
  output logic                            err_o,
  output logic [15:0]                     spr_bus_addr_o,
  output logic                            spr_bus_stb_o,
  output logic                            spr_bus_we_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o,
  input  logic                            spr_gpr_ack_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_i
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0]        TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GPR_ADDR_WIDTH:0] REM_ONE  = (GPR_ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_WDAT, S_ACCESS, S_RDOUT} state_t;

  state_t                          r_state;
  logic                            r_we;
  logic [GPR_ADDR_WIDTH-1:0]       r_idx;
  logic [GPR_ADDR_WIDTH:0]         r_rem;
  logic [TMO_W-1:0]                r_tmo;
  logic                            r_cmd_ready;
  logic                            r_wdat_ready;
  logic                            r_rdat_valid;
  logic [OPTION_OPERAND_WIDTH-1:0] r_rdat;
  logic                            r_done;
  logic                            r_err;
  logic [15:0]                     r_addr;
  logic                            r_stb;
  logic                            r_bus_we;
  logic [OPTION_OPERAND_WIDTH-1:0] r_bus_dat;

  // Group 0 GPR window: upper 7 bits fixed at 7'h2, index zero-extended to 9 bits.
  function automatic logic [15:0] f_addr(input logic [GPR_ADDR_WIDTH-1:0] idx);
    logic [8:0] w_pad;
    w_pad = '0;
    w_pad[GPR_ADDR_WIDTH-1:0] = idx;
    return {7'h2, w_pad};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_idx        <= '0;
      r_rem        <= '0;
      r_tmo        <= '0;
      r_cmd_ready  <= 1'b1;
      r_wdat_ready <= 1'b0;
      r_rdat_valid <= 1'b0;
      r_rdat       <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_stb        <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_dat    <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // Abort outranks any ack or data handshake in the same cycle.
      if (r_state != S_IDLE && abort_i) begin
        r_state      <= S_IDLE;
        r_cmd_ready  <= 1'b1;
        r_wdat_ready <= 1'b0;
        r_rdat_valid <= 1'b0;
        r_stb        <= 1'b0;
        r_bus_we     <= 1'b0;
        r_done       <= 1'b1;
        r_err        <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: if (cmd_valid_i) begin
            r_we  <= cmd_we_i;
            r_idx <= cmd_gpr_i;
            r_rem <= cmd_len_i;
            if (cmd_len_i == '0) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else if (cmd_we_i) begin
              r_state      <= S_WDAT;
              r_cmd_ready  <= 1'b0;
              r_wdat_ready <= 1'b1;
            end else begin
              r_state     <= S_ACCESS;
              r_cmd_ready <= 1'b0;
              r_stb       <= 1'b1;
              r_bus_we    <= 1'b0;
              r_addr      <= f_addr(cmd_gpr_i);
              r_tmo       <= '0;
            end
          end
          S_WDAT: if (wdat_valid_i) begin
            r_bus_dat    <= wdat_i;
            r_wdat_ready <= 1'b0;
            r_state      <= S_ACCESS;
            r_stb        <= 1'b1;
            r_bus_we     <= 1'b1;
            r_addr       <= f_addr(r_idx);
            r_tmo        <= '0;
          end
          S_ACCESS: begin
            // An ack in the final timeout cycle still completes the access.
            if (spr_gpr_ack_i) begin
              r_rem    <= r_rem - REM_ONE;
              r_idx    <= r_idx + GPR_ADDR_WIDTH'(1);
              r_stb    <= 1'b0;
              r_bus_we <= 1'b0;
              if (!r_we) begin
                r_rdat       <= spr_gpr_dat_i;
                r_rdat_valid <= 1'b1;
                r_state      <= S_RDOUT;
              end else if (r_rem == REM_ONE) begin
                r_state     <= S_IDLE;
                r_cmd_ready <= 1'b1;
                r_done      <= 1'b1;
              end else begin
                r_state      <= S_WDAT;
                r_wdat_ready <= 1'b1;
              end
            end else if (r_tmo == TMO_LAST) begin
              r_state     <= S_IDLE;
              r_cmd_ready <= 1'b1;
              r_stb       <= 1'b0;
              r_bus_we    <= 1'b0;
              r_done      <= 1'b1;
              r_err       <= 1'b1;
            end else begin
              r_tmo <= r_tmo + TMO_W'(1);
            end
          end
          S_RDOUT: if (rdat_ready_i) begin
            r_rdat_valid <= 1'b0;
            if (r_rem == '0) begin
              r_state     <= S_IDLE;
              r_cmd_ready <= 1'b1;
              r_done      <= 1'b1;
            end else begin
              r_state  <= S_ACCESS;
              r_stb    <= 1'b1;
              r_bus_we <= 1'b0;
              r_addr   <= f_addr(r_idx);
              r_tmo    <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready_o    = r_cmd_ready;
  assign wdat_ready_o   = r_wdat_ready;
  assign rdat_valid_o   = r_rdat_valid;
  assign rdat_o         = r_rdat;
  assign done_o         = r_done;
  assign err_o          = r_err;
  assign spr_bus_addr_o = r_addr;
  assign spr_bus_stb_o  = r_stb;
  assign spr_bus_we_o   = r_bus_we;
  assign spr_bus_dat_o  = r_bus_dat;

endmodule

// File: tb/tb_mor1kx_spr_gpr_initiator.sv
// Bench for mor1kx_spr_gpr_initiator: plays host and GPR responder, keeping a
// GPR array model and expected address/data sequence per burst.
module tb_mor1kx_spr_gpr_initiator;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int TMO = 255;
  localparam int NGPR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i = 1'b0;
  logic [AW-1:0] cmd_gpr_i = '0;
  logic [AW:0]   cmd_len_i = '0;
  logic          wdat_valid_i = 1'b0;
  logic [DW-1:0] wdat_i = '0;
  logic          wdat_ready_o;
  logic          rdat_valid_o;
  logic [DW-1:0] rdat_o;
  logic          rdat_ready_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          done_o;
  logic          err_o;
  logic [15:0]   spr_bus_addr_o;
  logic          spr_bus_stb_o;
  logic          spr_bus_we_o;
  logic [DW-1:0] spr_bus_dat_o;
  logic          spr_gpr_ack_i = 1'b0;
  logic [DW-1:0] spr_gpr_dat_i = '0;

  int assertCount = 0;
  int failCount   = 0;
  logic [DW-1:0] gprMem [NGPR];

  mor1kx_spr_gpr_initiator #(
    .OPTION_OPERAND_WIDTH(DW),
    .GPR_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_gpr_i(cmd_gpr_i), .cmd_len_i(cmd_len_i),
    .wdat_valid_i(wdat_valid_i), .wdat_i(wdat_i), .wdat_ready_o(wdat_ready_o),
    .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o), .rdat_ready_i(rdat_ready_i),
    .abort_i(abort_i), .done_o(done_o), .err_o(err_o),
    .spr_bus_addr_o(spr_bus_addr_o), .spr_bus_stb_o(spr_bus_stb_o),
    .spr_bus_we_o(spr_bus_we_o), .spr_bus_dat_o(spr_bus_dat_o),
    .spr_gpr_ack_i(spr_gpr_ack_i), .spr_gpr_dat_i(spr_gpr_dat_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    cmd_valid_i   = 1'b0;
    wdat_valid_i  = 1'b0;
    rdat_ready_i  = 1'b0;
    abort_i       = 1'b0;
    spr_gpr_ack_i = 1'b0;
  endtask

  // One burst, acting as host and responder. ackMode: 0 never ack, >0 ack on
  // that stb cycle, <0 random 1..3. abortStb: abort on that stb cycle of the first access.
  task automatic applyStimulus(input bit we, input int gpr, input int len, input int ackMode,
                               input int stallWord, input int stallCycles, input int abortStb,
                               input bit expErr);
    int issued = 0;
    int consumed = 0;
    int stbCount = 0;
    int stbTotal = 0;
    int thisDelay = 0;
    int stallLeft = 0;
    int curIdx = 0;
    bit ackPrev = 0;
    bit abortSent = 0;
    bit rdWaiting = 0;
    bit finished = 0;
    logic [DW-1:0] pendWord = '0;
    logic [DW-1:0] rdq[$];
    @(negedge clk);
    checkOutput("cmdReadyIdle", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_gpr_i   = AW'(gpr);
    cmd_len_i   = (AW + 1)'(len);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      clearInputs();
      if (ackPrev) checkOutput("stbGapAfterAck", 32'(spr_bus_stb_o), 32'd0);
      ackPrev = 0;
      if (done_o) begin
        finished = 1;
        checkOutput("doneErr", 32'(err_o), 32'(expErr));
        checkOutput("doneCmdReady", 32'(cmd_ready_o), 32'd1);
        checkOutput("doneStbLow", 32'(spr_bus_stb_o), 32'd0);
        checkOutput("doneNoRdat", 32'(rdat_valid_o), 32'd0);
        if (!expErr) checkOutput("wordCount", we ? 32'(issued) : 32'(consumed), 32'(len));
        if (expErr && abortStb == 0 && len != 0) checkOutput("timeoutStbCycles", 32'(stbTotal), 32'(TMO));
      end else if (abortSent) begin
        finished = 1;
        checkOutput("abortDone", 32'(done_o), 32'd1);
      end else begin
        checkOutput("cmdReadyBusy", 32'(cmd_ready_o), 32'd0);
        if (spr_bus_stb_o) begin
          curIdx = (gpr + issued) % NGPR;
          stbCount++;
          stbTotal++;
          if (stbCount == 1) thisDelay = (ackMode < 0) ? int'($urandom_range(1, 3)) : ackMode;
          checkOutput("stbAddr", 32'(spr_bus_addr_o), 32'h400 + 32'(curIdx));
          checkOutput("stbWe", 32'(spr_bus_we_o), 32'(we));
          if (we) checkOutput("stbWdat", spr_bus_dat_o, pendWord);
          if (abortStb != 0 && issued == 0 && stbCount == abortStb) begin
            abort_i = 1'b1;
            abortSent = 1;
          end
          if (thisDelay > 0 && stbCount == thisDelay) begin
            spr_gpr_ack_i = 1'b1;
            spr_gpr_dat_i = we ? DW'($urandom) : gprMem[curIdx];
            ackPrev = 1;
            stbCount = 0;
            if (!abortSent) begin
              if (we) gprMem[curIdx] = pendWord;
              else rdq.push_back(gprMem[curIdx]);
              issued++;
            end
          end
        end
        if (wdat_ready_o) begin
          checkOutput("wdatNoStb", 32'(spr_bus_stb_o), 32'd0);
          if ($urandom_range(0, 2) != 0) begin
            wdat_valid_i = 1'b1;
            wdat_i = DW'($urandom);
            pendWord = wdat_i;
          end
        end
        if (rdat_valid_o) begin
          checkOutput("rdatNoStb", 32'(spr_bus_stb_o), 32'd0);
          checkOutput("rdatPending", 32'(issued - consumed), 32'd1);
          if (rdq.size() != 0) checkOutput("rdatValue", rdat_o, rdq[0]);
          if (!rdWaiting) begin
            rdWaiting = 1;
            stallLeft = (consumed == stallWord) ? stallCycles : int'($urandom_range(0, 1));
          end
          if (stallLeft > 0) begin
            stallLeft--;
          end else begin
            rdat_ready_i = 1'b1;
            rdWaiting = 0;
            consumed++;
            if (rdq.size() != 0) rdq.delete(0);
          end
        end
      end
      if (!finished) @(negedge clk);
    end
    checkOutput("burstFinished", 32'(finished), 32'd1);
    clearInputs();
    @(negedge clk);
    checkOutput("donePulseOnce", 32'(done_o), 32'd0);
    checkOutput("errPulseOnce", 32'(err_o), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NGPR; i++) gprMem[i] = DW'($urandom);
    clearInputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstCmdReady", 32'(cmd_ready_o), 32'd1);
    checkOutput("rstStb", 32'(spr_bus_stb_o), 32'd0);
    checkOutput("rstDone", 32'(done_o), 32'd0);
    checkOutput("rstErr", 32'(err_o), 32'd0);
    checkOutput("rstWdatReady", 32'(wdat_ready_o), 32'd0);
    checkOutput("rstRdatValid", 32'(rdat_valid_o), 32'd0);
    checkOutput("rstAddr", 32'(spr_bus_addr_o), 32'd0);
    rst = 1'b1;

    $display("[TB] read len=1 gpr=3");
    gprMem[3] = 32'hDEADBEEF;
    applyStimulus(1'b0, 3, 1, 2, -1, 0, 0, 1'b0);
    $display("[TB] write len=3 gpr=30 with wrap, then read back");
    applyStimulus(1'b1, 30, 3, -1, -1, 0, 0, 1'b0);
    applyStimulus(1'b0, 30, 3, -1, -1, 0, 0, 1'b0);
    $display("[TB] write with ack withheld");
    applyStimulus(1'b1, 5, 2, 0, -1, 0, 0, 1'b1);
    $display("[TB] read len=4 with host stall on word 2");
    applyStimulus(1'b0, 10, 4, -1, 1, 5, 0, 1'b0);
    $display("[TB] zero-length command");
    applyStimulus(1'b0, 4, 0, -1, -1, 0, 0, 1'b1);
    $display("[TB] abort mid-access, then abort coincident with ack");
    applyStimulus(1'b0, 1, 3, 10, -1, 0, 3, 1'b1);
    applyStimulus(1'b1, 2, 2, 2, -1, 0, 2, 1'b1);
    applyStimulus(1'b0, 2, 2, 1, -1, 0, 0, 1'b0);

    $display("[TB] reset during access");
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_gpr_i = AW'(7); cmd_len_i = (AW + 1)'(2);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    checkOutput("rstPreStb", 32'(spr_bus_stb_o), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstMidStb", 32'(spr_bus_stb_o), 32'd0);
    checkOutput("rstMidCmdReady", 32'(cmd_ready_o), 32'd1);
    checkOutput("rstMidDone", 32'(done_o), 32'd0);
    checkOutput("rstMidErr", 32'(err_o), 32'd0);
    checkOutput("rstMidAddr", 32'(spr_bus_addr_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstPostDone", 32'(done_o), 32'd0);
    checkOutput("rstPostStb", 32'(spr_bus_stb_o), 32'd0);

    $display("[TB] randomized bursts");
    for (int n = 0; n < 10; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, NGPR - 1)),
                    int'($urandom_range(1, 8)), -1, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4)), 0, 1'b0);
    end
    applyStimulus(1'b0, 17, NGPR, 1, -1, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
